// File: rtl/iram_access_ctrl_if.sv
// Monitor-side request/ack bus for the instruction-RAM access controller.
interface iram_access_ctrl_if #(
  parameter int ADR_W = 12
);
  logic             mon_req;
  logic             mon_we;
  logic [ADR_W-1:0] mon_adr;
  logic [31:0]      mon_wdata;
  logic             mon_ack;
  logic [31:0]      mon_rdata;

  modport master (
    output mon_req, mon_we, mon_adr, mon_wdata,
    input  mon_ack, mon_rdata
  );

  modport slave (
    input  mon_req, mon_we, mon_adr, mon_wdata,
    output mon_ack, mon_rdata
  );
endinterface

// File: rtl/iram_access_ctrl.sv
// Sequences monitor read/write access to the CPU instruction RAM: halt, drain,
// single RAM access, ack.
//
// state  | meaning
// IDLE   | no access; fetch owns the RAM
// HALT   | fetch stalled, draining the pipeline for DRAIN_CYC cycles
// ACC_W  | single-cycle RAM write pulse
// ACC_R  | RAM read port steered to the monitor address
// RD_CAP | read data returning from RAM, captured at end of cycle
// DONE   | one-cycle ack; a held request starts the next access without re-drain
module iram_access_ctrl #(
  parameter int ADR_W     = 12,
  parameter int DRAIN_CYC = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  iram_access_ctrl_if.slave  mon,
  input  logic               cpu_run,
  output logic               cpu_halt_req,
  output logic               i_read_sel,
  output logic [ADR_W-1:0]   i_ram_radr,
  output logic [ADR_W-1:0]   i_ram_wadr,
  output logic [31:0]        i_ram_wdata,
  output logic               i_ram_wen,
  input  logic [31:0]        i_ram_rdata
);

  localparam int CNT_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DRAIN_CYC - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HALT   = 3'd1,
    ACC_W  = 3'd2,
    ACC_R  = 3'd3,
    RD_CAP = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             we_q, we_d;
  logic [ADR_W-1:0] adr_q, adr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             halt_q, halt_d;
  logic             read_sel_q, read_sel_d;
  logic             wen_q, wen_d;
  logic             ack_q, ack_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    adr_d   = adr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;

    case (state_q)
      IDLE: begin
        if (mon.mon_req) begin
          we_d    = mon.mon_we;
          adr_d   = mon.mon_adr;
          wdata_d = mon.mon_wdata;
          if (cpu_run) begin
            state_d = HALT;
            cnt_d   = CNT_LOAD;
          end else begin
            state_d = mon.mon_we ? ACC_W : ACC_R;
          end
        end
      end
      HALT: begin
        if (cnt_q == '0) state_d = we_q ? ACC_W : ACC_R;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ACC_W:  state_d = DONE;
      ACC_R:  state_d = RD_CAP;
      RD_CAP: begin
        rdata_d = i_ram_rdata;
        state_d = DONE;
      end
      DONE: begin
        // pipeline is still halted, so a held request skips the drain
        if (mon.mon_req) begin
          we_d    = mon.mon_we;
          adr_d   = mon.mon_adr;
          wdata_d = mon.mon_wdata;
          state_d = mon.mon_we ? ACC_W : ACC_R;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    halt_d     = (state_d != IDLE);
    read_sel_d = (state_d == ACC_R) || (state_d == RD_CAP);
    wen_d      = (state_d == ACC_W);
    ack_d      = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      adr_q      <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      halt_q     <= 1'b0;
      read_sel_q <= 1'b0;
      wen_q      <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      adr_q      <= adr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      halt_q     <= halt_d;
      read_sel_q <= read_sel_d;
      wen_q      <= wen_d;
      ack_q      <= ack_d;
    end
  end

  // gating with rst_n keeps a write from committing on the reset edge
  assign i_ram_wen     = wen_q & rst_n;
  assign cpu_halt_req  = halt_q;
  assign i_read_sel    = read_sel_q;
  assign i_ram_radr    = adr_q;
  assign i_ram_wadr    = adr_q;
  assign i_ram_wdata   = wdata_q;
  assign mon.mon_ack   = ack_q;
  assign mon.mon_rdata = rdata_q;

endmodule
